neuron_param_loader: RTL and testbench

- Upstream feeder for neuron_lif.
- Accepts byte-wide host writes over a valid/ready handshake and assembles SYNAPSES-wide input and weight vectors, plus shift and threshold, in staging registers.
- On a RUN command it commits the staging registers to its outputs, which drive the neuron directly. It then pulses the neuron's enable for a programmed number of ticks and counts the spikes the neuron produces.
- This lets a narrow chip-level IO bus drive a 32-synapse neuron.

---
 rtl/nlif_pkg.sv | 30 +++
 rtl/byte_shift_reg.sv | 34 +++
 rtl/neuron_param_loader.sv | 180 ++++++++++++++++++
 tb/tb_neuron_param_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nlif_pkg.sv
// Shared definitions for the neuron parameter loader: host address map, FSM states, counter width.
package nlif_pkg;

    localparam int unsigned ADDR_BITS        = 3;
    localparam int unsigned BYTE_BITS        = 8;
    localparam int unsigned SPIKE_COUNT_BITS = 8;
    localparam int unsigned SHIFT_BITS       = 3;

    localparam logic [ADDR_BITS-1:0] ADDR_INPUTS  = 3'd0;
    localparam logic [ADDR_BITS-1:0] ADDR_WEIGHTS = 3'd1;
    localparam logic [ADDR_BITS-1:0] ADDR_SHIFT   = 3'd2;
    localparam logic [ADDR_BITS-1:0] ADDR_THRESH  = 3'd3;
    localparam logic [ADDR_BITS-1:0] ADDR_RUN     = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Saturating increment for the spike counter.
    function automatic logic [SPIKE_COUNT_BITS-1:0] sat_inc(
        input logic [SPIKE_COUNT_BITS-1:0] value
    );
        if (value == {SPIKE_COUNT_BITS{1'b1}}) begin
            return value;
        end
        return value + SPIKE_COUNT_BITS'(1);
    endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// Byte-wide right-shifting staging register: new bytes enter at the top, oldest byte drops out of the bottom.
module byte_shift_reg import nlif_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [BYTE_BITS-1:0] data_in,
    output logic [WIDTH-1:0]     q
);

    generate
        if (WIDTH == BYTE_BITS) begin : g_single_byte
            // Single-byte register: every load simply replaces the content.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (load) begin
                    q <= data_in;
                end
            end
        end else begin : g_multi_byte
            // Shift right by one byte, new byte lands in the top lane.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (load) begin
                    q <= {data_in, q[WIDTH-1:BYTE_BITS]};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/neuron_param_loader.sv
// Host-side loader for neuron_lif: stages byte writes, commits them on RUN, then drives enable for N ticks and counts spikes.
module neuron_param_loader import nlif_pkg::*; #(
    parameter int unsigned SYNAPSES       = 32,
    parameter int unsigned THRESHOLD_BITS = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic [2:0]                  addr,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic [SYNAPSES-1:0]         inputs,
    output logic [SYNAPSES-1:0]         weights,
    output logic [2:0]                  shift,
    output logic [THRESHOLD_BITS-1:0]   threshold,
    output logic                        enable,
    input  logic                        is_spike,
    output logic [7:0]                  spike_count,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned TICK_BITS = 8;

    state_e                       state_q;
    state_e                       state_d;

    logic                         accept;
    logic                         wr_inputs;
    logic                         wr_weights;
    logic                         wr_shift;
    logic                         wr_thresh;
    logic                         commit;
    logic                         start;
    logic                         last_tick;

    logic [SYNAPSES-1:0]          stg_inputs;
    logic [SYNAPSES-1:0]          stg_weights;
    logic [SHIFT_BITS-1:0]        stg_shift;
    logic [THRESHOLD_BITS-1:0]    stg_thresh;
    logic [TICK_BITS-1:0]         remaining_q;

    // Staging vector for input spikes.
    byte_shift_reg #(
        .WIDTH (SYNAPSES)
    ) u_inputs_stg (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_inputs),
        .data_in (data_in),
        .q       (stg_inputs)
    );

    // Staging vector for binary weights.
    byte_shift_reg #(
        .WIDTH (SYNAPSES)
    ) u_weights_stg (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_weights),
        .data_in (data_in),
        .q       (stg_weights)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake decode, write strobes and next-state logic.
    always_comb begin
        data_ready = 1'b0;
        accept     = 1'b0;
        wr_inputs  = 1'b0;
        wr_weights = 1'b0;
        wr_shift   = 1'b0;
        wr_thresh  = 1'b0;
        commit     = 1'b0;
        start      = 1'b0;
        last_tick  = 1'b0;
        state_d    = state_q;

        data_ready = (state_q == IDLE);
        accept     = data_valid && data_ready;

        if (accept) begin
            case (addr)
                ADDR_INPUTS:  wr_inputs  = 1'b1;
                ADDR_WEIGHTS: wr_weights = 1'b1;
                ADDR_SHIFT:   wr_shift   = 1'b1;
                ADDR_THRESH:  wr_thresh  = 1'b1;
                ADDR_RUN:     commit     = 1'b1;
                default:      ;
            endcase
        end

        start = commit && (data_in != 8'd0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                last_tick = (remaining_q == TICK_BITS'(1));
                if (last_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scalar staging registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_shift  <= '0;
            stg_thresh <= '0;
        end else begin
            if (wr_shift) begin
                stg_shift <= data_in[SHIFT_BITS-1:0];
            end
            if (wr_thresh) begin
                stg_thresh <= data_in[THRESHOLD_BITS-1:0];
            end
        end
    end

    // Committed operands: only a RUN write updates them, so they hold steady through a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            inputs    <= '0;
            weights   <= '0;
            shift     <= '0;
            threshold <= '0;
        end else if (commit) begin
            inputs    <= stg_inputs;
            weights   <= stg_weights;
            shift     <= stg_shift;
            threshold <= stg_thresh;
        end
    end

    // Run control: tick counter, enable/busy, done pulse and saturating spike counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= '0;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_count <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                remaining_q <= data_in;
                enable      <= 1'b1;
                busy        <= 1'b1;
                spike_count <= '0;
            end else if (state_q == RUN) begin
                if (enable && is_spike) begin
                    spike_count <= sat_inc(spike_count);
                end
                if (last_tick) begin
                    remaining_q <= '0;
                    enable      <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end else begin
                    remaining_q <= remaining_q - TICK_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed self-checking bench for neuron_param_loader.
module tb_neuron_param_loader;

    localparam int unsigned SYNAPSES       = 32;
    localparam int unsigned THRESHOLD_BITS = 6;

    logic                       clk;
    logic                       reset;
    logic [7:0]                 data_in;
    logic [2:0]                 addr;
    logic                       data_valid;
    logic                       data_ready;
    logic [SYNAPSES-1:0]        inputs;
    logic [SYNAPSES-1:0]        weights;
    logic [2:0]                 shift;
    logic [THRESHOLD_BITS-1:0]  threshold;
    logic                       enable;
    logic                       is_spike;
    logic [7:0]                 spike_count;
    logic                       busy;
    logic                       done;

    int n_checks;
    int n_errors;

    neuron_param_loader #(
        .SYNAPSES       (SYNAPSES),
        .THRESHOLD_BITS (THRESHOLD_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .addr        (addr),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .inputs      (inputs),
        .weights     (weights),
        .shift       (shift),
        .threshold   (threshold),
        .enable      (enable),
        .is_spike    (is_spike),
        .spike_count (spike_count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [31:0] exp_inputs;
        logic [31:0] exp_weights;
        logic [2:0]  exp_shift;
        logic [5:0]  exp_thresh;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one write in the current cycle and let it be accepted on the next edge.
    task automatic write_now(input logic [2:0] a, input logic [7:0] d);
        addr       = a;
        data_in    = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        int en_cycles;
        int waited;
        int bad_seen;

        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        data_in    = 8'd0;
        addr       = 3'd0;
        data_valid = 1'b0;
        is_spike   = 1'b0;

        // Load vectors: committed outputs stay 0 until the RUN write.
        vecs[0]  = '{3'd0, 8'h11, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[1]  = '{3'd0, 8'h22, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[2]  = '{3'd0, 8'h33, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[3]  = '{3'd0, 8'h44, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[4]  = '{3'd1, 8'hFF, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[5]  = '{3'd1, 8'hFF, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[6]  = '{3'd1, 8'hFF, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[7]  = '{3'd1, 8'hFF, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[8]  = '{3'd2, 8'h03, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[9]  = '{3'd3, 8'h05, 32'h0, 32'h0, 3'd0, 6'd0};
        vecs[10] = '{3'd4, 8'h00, 32'h44332211, 32'hFFFFFFFF, 3'd3, 6'd5};

        // Reset state
        repeat (2) tick();
        chk("rst_inputs",    64'(inputs),      64'h0);
        chk("rst_weights",   64'(weights),     64'h0);
        chk("rst_shift",     64'(shift),       64'h0);
        chk("rst_threshold", 64'(threshold),   64'h0);
        chk("rst_enable",    64'(enable),      64'h0);
        chk("rst_busy",      64'(busy),        64'h0);
        chk("rst_done",      64'(done),        64'h0);
        chk("rst_count",     64'(spike_count), 64'h0);
        chk("rst_ready",     64'(data_ready),  64'h1);
        reset = 1'b0;
        tick();

        // Load and commit (RUN N=0)
        for (int i = 0; i < 11; i++) begin
            chk("load_ready", 64'(data_ready), 64'h1);
            write_now(vecs[i].addr, vecs[i].data);
            chk("load_inputs",    64'(inputs),    64'(vecs[i].exp_inputs));
            chk("load_weights",   64'(weights),   64'(vecs[i].exp_weights));
            chk("load_shift",     64'(shift),     64'(vecs[i].exp_shift));
            chk("load_threshold", 64'(threshold), 64'(vecs[i].exp_thresh));
            chk("load_enable",    64'(enable),    64'h0);
            chk("load_done",      64'(done),      64'h0);
        end
        tick();
        chk("run0_enable_after", 64'(enable), 64'h0);
        chk("run0_done_after",   64'(done),   64'h0);

        // Reserved address is accepted and changes nothing
        write_now(3'd6, 8'hA5);
        chk("rsvd_ready",  64'(data_ready), 64'h1);
        chk("rsvd_enable", 64'(enable),     64'h0);
        write_now(3'd4, 8'h00);
        chk("rsvd_inputs", 64'(inputs),     64'h44332211);
        chk("rsvd_shift",  64'(shift),      64'h3);

        // Run N=5 with spikes in t+2 and t+4
        write_now(3'd4, 8'd5);
        for (int k = 1; k <= 6; k++) begin
            is_spike = (k == 2 || k == 4);
            chk("run5_enable", 64'(enable),     (k <= 5) ? 64'h1 : 64'h0);
            chk("run5_busy",   64'(busy),       (k <= 5) ? 64'h1 : 64'h0);
            chk("run5_ready",  64'(data_ready), (k == 6) ? 64'h1 : 64'h0);
            chk("run5_done",   64'(done),       (k == 6) ? 64'h1 : 64'h0);
            tick();
        end
        is_spike = 1'b0;
        chk("run5_count",      64'(spike_count), 64'd2);
        chk("run5_done_clear", 64'(done),        64'h0);

        // Stall during RUN N=3, accept in the done cycle
        write_now(3'd4, 8'd3);
        addr       = 3'd2;
        data_in    = 8'd7;
        data_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("stall_ready",  64'(data_ready), (k == 4) ? 64'h1 : 64'h0);
            chk("stall_enable", 64'(enable),     (k <= 3) ? 64'h1 : 64'h0);
            chk("stall_done",   64'(done),       (k == 4) ? 64'h1 : 64'h0);
            tick();
        end
        data_valid = 1'b0;
        chk("stall_commit_hold", 64'(shift), 64'h3);
        chk("stall_count",       64'(spike_count), 64'h0);
        write_now(3'd4, 8'd0);
        chk("stall_commit_new",  64'(shift),  64'h7);
        chk("stall_inputs_keep", 64'(inputs), 64'h44332211);

        // Saturation run: N=255 then N=10 with is_spike tied high
        is_spike = 1'b1;
        write_now(3'd4, 8'd255);
        en_cycles = 0;
        waited    = 0;
        while (!done && waited < 300) begin
            if (enable) en_cycles++;
            waited++;
            tick();
        end
        chk("sat_done_seen",  64'(done),        64'h1);
        chk("sat_en_cycles",  64'(en_cycles),   64'd255);
        chk("sat_count",      64'(spike_count), 64'd255);
        tick();
        tick();
        chk("sat_count_hold", 64'(spike_count), 64'd255);
        write_now(3'd4, 8'd10);
        chk("sat_count_clear", 64'(spike_count), 64'd0);
        waited = 0;
        while (!done && waited < 30) begin
            waited++;
            tick();
        end
        chk("sat10_done_seen", 64'(done),        64'h1);
        chk("sat10_count",     64'(spike_count), 64'd10);
        tick();

        // Abort: reset during the 4th enable cycle of RUN N=20
        write_now(3'd4, 8'd20);
        tick();
        tick();
        tick();
        chk("abort_pre_enable", 64'(enable),      64'h1);
        chk("abort_pre_count",  64'(spike_count), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_enable",    64'(enable),      64'h0);
        chk("abort_busy",      64'(busy),        64'h0);
        chk("abort_done",      64'(done),        64'h0);
        chk("abort_count",     64'(spike_count), 64'h0);
        chk("abort_inputs",    64'(inputs),      64'h0);
        chk("abort_weights",   64'(weights),     64'h0);
        chk("abort_shift",     64'(shift),       64'h0);
        chk("abort_threshold", 64'(threshold),   64'h0);
        chk("abort_ready",     64'(data_ready),  64'h1);
        bad_seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done || enable || !data_ready) bad_seen++;
        end
        chk("abort_quiet",       64'(bad_seen),    64'd0);
        chk("abort_count_after", 64'(spike_count), 64'd0);
        is_spike = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
